// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: mode/direction encodings
// and the per-mode initial pattern used for reload and wrap detection.
package led_pkg;

    // The initial pattern is built at this width and then cut down to N_LED.
    // N_LED must not exceed LED_MAX.
    localparam int LED_MAX = 64;

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BAR    = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic {
        BNC_UP   = 1'b0,
        BNC_DOWN = 1'b1
    } bounce_e;

    function automatic logic [LED_MAX-1:0] init_pattern(input logic [1:0] mode,
                                                        input logic       dir,
                                                        input int         n);
        logic [LED_MAX-1:0] one;
        logic [LED_MAX-1:0] pat;
        one = {{(LED_MAX-1){1'b0}}, 1'b1};
        pat = {LED_MAX{1'b0}};
        case (mode)
            MODE_RUN: begin
                if (dir == DIR_DOWN) begin
                    pat = one << (n - 1);
                end else begin
                    pat = one;
                end
            end
            MODE_BOUNCE: pat = one;
            MODE_BAR:    pat = {LED_MAX{1'b0}};
            MODE_BLINK:  pat = {LED_MAX{1'b0}};
            default:     pat = {LED_MAX{1'b0}};
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Pattern-control and LED-output signal bundle between the controller side
// (master) and the sequencer (slave).
interface led_pattern_seq_if #(
    parameter int N_LED = 8
) ();
    logic             clk_show;
    logic [1:0]       mode;
    logic             dir;
    logic             pause;
    logic [N_LED-1:0] led;
    logic             step_pulse;
    logic             pattern_done;

    modport master (
        output clk_show, mode, dir, pause,
        input  led, step_pulse, pattern_done
    );

    modport slave (
        input  clk_show, mode, dir, pause,
        output led, step_pulse, pattern_done
    );
endinterface

// File: rtl/sync_edge_det.sv
// Synchronises the slow clk_show wave into clk and flags each rising edge.
// Every flop resets to 1 so a level held high through reset is not a step.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic step
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser chain plus one-cycle history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign step = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: advances RUN/BOUNCE/BAR/BLINK patterns one step per
// synchronised clk_show rising edge; a mode/dir change reloads the pattern.
module led_pattern_seq
    import led_pkg::*;
#(
    parameter int N_LED       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    led_pattern_seq_if.slave bus
);

    logic             step_s;
    logic             reload_s;
    logic [N_LED-1:0] init_new_s;
    logic [N_LED-1:0] init_cur_s;
    logic [N_LED-1:0] adv_led_s;
    bounce_e          adv_bounce_s;

    logic [1:0]       cur_mode_r;
    logic             cur_dir_r;
    logic [N_LED-1:0] led_r;
    bounce_e          bounce_r;
    logic             step_pulse_r;
    logic             done_r;

    logic [1:0]       cur_mode_nxt_s;
    logic             cur_dir_nxt_s;
    logic [N_LED-1:0] led_nxt_s;
    bounce_e          bounce_nxt_s;
    logic             step_pulse_nxt_s;
    logic             done_nxt_s;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.clk_show),
        .step     (step_s)
    );

    assign reload_s   = ({bus.mode, bus.dir} != {cur_mode_r, cur_dir_r});
    assign init_new_s = N_LED'(init_pattern(bus.mode, bus.dir, N_LED));
    assign init_cur_s = N_LED'(init_pattern(cur_mode_r, cur_dir_r, N_LED));

    // One-step advance of the current pattern, independent of whether it is applied
    always_comb begin
        adv_led_s    = led_r;
        adv_bounce_s = bounce_r;
        case (cur_mode_r)
            MODE_RUN: begin
                if (cur_dir_r == DIR_UP) begin
                    adv_led_s = {led_r[N_LED-2:0], led_r[N_LED-1]};
                end else begin
                    adv_led_s = {led_r[0], led_r[N_LED-1:1]};
                end
            end
            MODE_BOUNCE: begin
                // Flip the flag on the step that lands on an end LED so it lights once
                if (bounce_r == BNC_UP) begin
                    adv_led_s    = {led_r[N_LED-2:0], 1'b0};
                    adv_bounce_s = adv_led_s[N_LED-1] ? BNC_DOWN : BNC_UP;
                end else begin
                    adv_led_s    = {1'b0, led_r[N_LED-1:1]};
                    adv_bounce_s = adv_led_s[0] ? BNC_UP : BNC_DOWN;
                end
            end
            MODE_BAR: begin
                if (&led_r) begin
                    adv_led_s = {N_LED{1'b0}};
                end else if (cur_dir_r == DIR_UP) begin
                    adv_led_s = {led_r[N_LED-2:0], 1'b1};
                end else begin
                    adv_led_s = {1'b1, led_r[N_LED-1:1]};
                end
            end
            MODE_BLINK: adv_led_s = ~led_r;
            default:    adv_led_s = led_r;
        endcase
    end

    // Next-state selection: reload beats step; paused steps are dropped
    always_comb begin
        cur_mode_nxt_s   = cur_mode_r;
        cur_dir_nxt_s    = cur_dir_r;
        led_nxt_s        = led_r;
        bounce_nxt_s     = bounce_r;
        step_pulse_nxt_s = 1'b0;
        done_nxt_s       = 1'b0;
        if (reload_s) begin
            cur_mode_nxt_s = bus.mode;
            cur_dir_nxt_s  = bus.dir;
            led_nxt_s      = init_new_s;
            bounce_nxt_s   = BNC_UP;
        end else if (step_s && !bus.pause) begin
            led_nxt_s        = adv_led_s;
            bounce_nxt_s     = adv_bounce_s;
            step_pulse_nxt_s = 1'b1;
            done_nxt_s       = (adv_led_s == init_cur_s);
        end else begin
            led_nxt_s = led_r;
        end
    end

    // Config latch, pattern register and registered status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_mode_r   <= MODE_RUN;
            cur_dir_r    <= DIR_UP;
            led_r        <= {{(N_LED-1){1'b0}}, 1'b1};
            bounce_r     <= BNC_UP;
            step_pulse_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            cur_mode_r   <= cur_mode_nxt_s;
            cur_dir_r    <= cur_dir_nxt_s;
            led_r        <= led_nxt_s;
            bounce_r     <= bounce_nxt_s;
            step_pulse_r <= step_pulse_nxt_s;
            done_r       <= done_nxt_s;
        end
    end

    assign bus.led          = led_r;
    assign bus.step_pulse   = step_pulse_r;
    assign bus.pattern_done = done_r;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed, table-driven bench for led_pattern_seq with N_LED=8, SYNC_STAGES=2.
module tb_led_pattern_seq;

    localparam int N = 8;

    typedef struct {
        logic [1:0] mode;
        logic       dir;
        logic [7:0] led;
        logic       done;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    led_pattern_seq_if #(.N_LED(N)) bus ();

    led_pattern_seq #(.N_LED(N), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_init(input logic [1:0] m, input logic d);
        case (m)
            2'd0:    return d ? 8'h80 : 8'h01;
            2'd1:    return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void add(input logic [1:0] m, input logic d, input logic [7:0] l, input logic dn);
        vec_t v;
        v.mode = m; v.dir = d; v.led = l; v.done = dn;
        vecs.push_back(v);
    endfunction

    // One full clk_show period (4 clk high, 4 clk low); called at a negedge
    task automatic show_period(output logic [7:0] led_o, output int pulses, output int dones, output int first);
        pulses = 0; dones = 0; first = -1;
        bus.clk_show = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.step_pulse) begin
                pulses++;
                if (first < 0) first = c;
            end
            if (bus.pattern_done) dones++;
            if (c == 4) bus.clk_show = 1'b0;
        end
        led_o = bus.led;
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic d);
        bus.mode = m;
        bus.dir  = d;
        @(negedge clk);
        check("reload_led", {24'd0, bus.led}, {24'd0, exp_init(m, d)});
        check("reload_no_pulse", {31'd0, bus.step_pulse}, 32'd0);
        check("reload_no_done", {31'd0, bus.pattern_done}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] l;
        int p, dn, f;
        logic [1:0] cm;
        logic cd;

        bus.clk_show = 1'b0; bus.mode = 2'd0; bus.dir = 1'b0; bus.pause = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_led", {24'd0, bus.led}, 32'h01);
        check("rst_pulse", {31'd0, bus.step_pulse}, 32'd0);
        check("rst_done", {31'd0, bus.pattern_done}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        add(2'd0, 1'b0, 8'h02, 1'b0); add(2'd0, 1'b0, 8'h04, 1'b0); add(2'd0, 1'b0, 8'h08, 1'b0);
        add(2'd0, 1'b0, 8'h10, 1'b0); add(2'd0, 1'b0, 8'h20, 1'b0); add(2'd0, 1'b0, 8'h40, 1'b0);
        add(2'd0, 1'b0, 8'h80, 1'b0); add(2'd0, 1'b0, 8'h01, 1'b1); add(2'd0, 1'b0, 8'h02, 1'b0);
        add(2'd1, 1'b0, 8'h02, 1'b0); add(2'd1, 1'b0, 8'h04, 1'b0); add(2'd1, 1'b0, 8'h08, 1'b0);
        add(2'd1, 1'b0, 8'h10, 1'b0); add(2'd1, 1'b0, 8'h20, 1'b0); add(2'd1, 1'b0, 8'h40, 1'b0);
        add(2'd1, 1'b0, 8'h80, 1'b0); add(2'd1, 1'b0, 8'h40, 1'b0); add(2'd1, 1'b0, 8'h20, 1'b0);
        add(2'd1, 1'b0, 8'h10, 1'b0); add(2'd1, 1'b0, 8'h08, 1'b0); add(2'd1, 1'b0, 8'h04, 1'b0);
        add(2'd1, 1'b0, 8'h02, 1'b0); add(2'd1, 1'b0, 8'h01, 1'b1);
        add(2'd2, 1'b1, 8'h80, 1'b0); add(2'd2, 1'b1, 8'hC0, 1'b0); add(2'd2, 1'b1, 8'hE0, 1'b0);
        add(2'd2, 1'b1, 8'hF0, 1'b0); add(2'd2, 1'b1, 8'hF8, 1'b0); add(2'd2, 1'b1, 8'hFC, 1'b0);
        add(2'd2, 1'b1, 8'hFE, 1'b0); add(2'd2, 1'b1, 8'hFF, 1'b0); add(2'd2, 1'b1, 8'h00, 1'b1);
        add(2'd2, 1'b0, 8'h01, 1'b0); add(2'd2, 1'b0, 8'h03, 1'b0); add(2'd2, 1'b0, 8'h07, 1'b0);
        add(2'd0, 1'b1, 8'h40, 1'b0); add(2'd0, 1'b1, 8'h20, 1'b0);

        cm = 2'd0; cd = 1'b0;
        foreach (vecs[i]) begin
            if (vecs[i].mode != cm || vecs[i].dir != cd) begin
                cm = vecs[i].mode; cd = vecs[i].dir;
                set_cfg(cm, cd);
            end
            show_period(l, p, dn, f);
            check($sformatf("vec%0d_led", i), {24'd0, l}, {24'd0, vecs[i].led});
            check($sformatf("vec%0d_pulses", i), p, 1);
            check($sformatf("vec%0d_done", i), dn, {31'd0, vecs[i].done});
            check($sformatf("vec%0d_latency", i), f, 3);
        end

        // Reload on the very cycle a step is detected: step is dropped
        set_cfg(2'd0, 1'b0);
        repeat (3) show_period(l, p, dn, f);
        check("pre_reload_led", {24'd0, bus.led}, 32'h08);
        bus.clk_show = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.mode = 2'd3;
        @(negedge clk);
        check("step_reload_led", {24'd0, bus.led}, 32'h00);
        check("step_reload_pulse", {31'd0, bus.step_pulse}, 32'd0);
        p = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) bus.clk_show = 1'b0;
            @(negedge clk);
            if (bus.step_pulse) p++;
        end
        check("step_reload_no_late_pulse", p, 0);
        show_period(l, p, dn, f);
        check("blink_ff", {24'd0, l}, 32'hFF);
        check("blink_ff_done", dn, 0);
        show_period(l, p, dn, f);
        check("blink_00", {24'd0, l}, 32'h00);
        check("blink_00_done", dn, 1);

        // Pause discards steps; reload still works while paused
        bus.pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            show_period(l, p, dn, f);
            check("pause_led", {24'd0, l}, 32'h00);
            check("pause_pulse", p, 0);
        end
        set_cfg(2'd0, 1'b0);
        bus.pause = 1'b0;
        show_period(l, p, dn, f);
        check("unpause_led", {24'd0, l}, 32'h02);
        check("unpause_pulses", p, 1);

        // Mid-pattern reset with clk_show held high through release
        bus.clk_show = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_led", {24'd0, bus.led}, 32'h01);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        p = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.step_pulse) p++;
        end
        bus.clk_show = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.step_pulse) p++;
        end
        check("held_high_no_step", p, 0);
        check("held_high_led", {24'd0, bus.led}, 32'h01);
        show_period(l, p, dn, f);
        check("after_low_led", {24'd0, l}, 32'h02);
        check("after_low_pulses", p, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
